axi_mem_bridge: RTL and testbench
=================================

AXI_MEM_BRIDGE -- requirements
Module: axi_mem_bridge

Interface
REQ-001 The block SHALL be clocked by a single clock and SHALL use an asynchronous, active-high reset.
REQ-002 Parameter WAIT_CYCLES, default 3, SHALL set the number of clock cycles a memory request is held (legal range 1..15).
REQ-003 Port clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port rst  input  1  asynchronous reset, active high.
REQ-005 Ports S_AXI_AWADDR/ARADDR  input  32 each  write/read address from the MicroBlaze data port.
REQ-006 Ports S_AXI_AWVALID, S_AXI_WVALID, S_AXI_ARVALID, S_AXI_BREADY, S_AXI_RREADY  input  1 each  AXI4-Lite handshakes.
REQ-007 Port S_AXI_WDATA  input  32  write data.
REQ-008 Ports S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID  output  1 each  AXI4-Lite handshakes.
REQ-009 Ports S_AXI_BRESP, S_AXI_RRESP  output  2 each  response codes; S_AXI_RDATA  output  32  read data.
REQ-010 Ports mem_awaddr, mem_araddr, mem_wdata  output  32 each  address/data to the memory controller.
REQ-011 Ports mem_wr_req, mem_rd_req  output  1 each  write/read strobes to the memory controller; mem_rdata  input  32  read data from it.

Function
REQ-012 FSM states SHALL be IDLE, WR_ACC, WR_RESP, RD_ACC, RD_RESP; one transaction outstanding at a time.
REQ-013 S_AXI_ARREADY SHALL equal (state==IDLE).
REQ-014 S_AXI_AWREADY and S_AXI_WREADY SHALL both equal (state==IDLE && AWVALID && WVALID && !ARVALID); AW and W are accepted only together.
REQ-015 Simultaneous valid read and write in IDLE: read SHALL win; write stays pending and is accepted on the next return to IDLE.
REQ-016 On AR handshake: latch ARADDR to mem_araddr, enter RD_ACC, clear wait counter.
REQ-017 On AW/W handshake: latch AWADDR to mem_awaddr and WDATA to mem_wdata, enter WR_ACC, clear wait counter.
REQ-018 mem_rd_req SHALL be high exactly while in RD_ACC, and mem_wr_req exactly while in WR_ACC, each for exactly WAIT_CYCLES cycles.
REQ-019 On the last RD_ACC cycle's edge: register mem_rdata into S_AXI_RDATA, RRESP=2'b00, enter RD_RESP with RVALID=1.
REQ-020 On the last WR_ACC cycle's edge: BRESP=2'b00, enter WR_RESP with BVALID=1.
REQ-021 RVALID/BVALID, RDATA and RESP SHALL stay stable until RREADY/BREADY is high at an edge; the FSM then returns to IDLE.
REQ-022 Handshake-to-response latency SHALL be WAIT_CYCLES cycles when READY is already high; back-to-back transactions have one IDLE cycle between them.
REQ-023 mem_araddr/mem_awaddr/mem_wdata SHALL hold their last latched values outside the access states.

Reset
REQ-024 When rst asserts, the block SHALL immediately enter IDLE; all VALID, mem_*_req outputs go 0; RDATA, RESP, mem address/data outputs go 0; the wait counter goes 0.
REQ-025 Reset during RD_ACC/WR_ACC/RESP SHALL abandon the transaction with no response issued afterward.

Configuration
REQ-026 With macro BRIDGE_ADDR_CHECK_EN defined, an accepted address with bits [15:14] != 2'b00 SHALL skip the ACC state (no mem_*_req pulse), go directly to RESP on the next edge with RESP=2'b10 (SLVERR) and RDATA=0.
REQ-027 Without BRIDGE_ADDR_CHECK_EN, all addresses SHALL be treated as valid and RESP is always 2'b00.

Verification
REQ-028 Read: ARADDR=0x0012_0034, mem_rdata=0x00AB_CD5A, RREADY=1, WAIT_CYCLES=3 -> mem_rd_req high 3 cycles, mem_araddr=0x0012_0034, RVALID with RDATA=0x00AB_CD5A, RRESP=0.
REQ-029 Write: AWADDR=0x0005_0010, WDATA=0xBEEF_00C3 -> AWREADY/WREADY same cycle, mem_wr_req high 3 cycles, mem_wdata=0xBEEF_00C3, BVALID, BRESP=0.
REQ-030 Simultaneous AR and AW+W in IDLE -> read completes first, write accepted after the read's response handshake.
REQ-031 RREADY held low 5 cycles -> RVALID and RDATA stable for those 5 cycles, no new ARREADY until after handshake.
REQ-032 rst pulsed on the 2nd cycle of WR_ACC -> mem_wr_req falls asynchronously, BVALID never asserts, next read runs normally.
REQ-033 With BRIDGE_ADDR_CHECK_EN, ARADDR=0x0000_4000 -> no mem_rd_req, RVALID next cycle, RRESP=2'b10, RDATA=0.

Source files
------------

// File: rtl/axi_mem_bridge.sv
// AXI4-Lite slave to simple memory-controller bridge.
// One transaction in flight; each memory access holds its request for WAIT_CYCLES cycles.
// Optional build macro BRIDGE_ADDR_CHECK_EN: addresses with bits [15:14] != 0 get SLVERR
// without touching memory.
module axi_mem_bridge #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output logic [31:0] mem_awaddr,
    output logic [31:0] mem_araddr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_req,
    output logic        mem_rd_req,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StWrAcc,
        StWrResp,
        StRdAcc,
        StRdResp
    } state_e;

    localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;

    logic idle;
    logic aw_hs;
    logic ar_bad;
    logic aw_bad;

    assign idle  = (state_q == StIdle);
    // Read has priority: a pending AR blocks the write handshake.
    assign aw_hs = idle && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_ARVALID;

`ifdef BRIDGE_ADDR_CHECK_EN
    assign ar_bad = (S_AXI_ARADDR[15:14] != 2'b00);
    assign aw_bad = (S_AXI_AWADDR[15:14] != 2'b00);
`else
    assign ar_bad = 1'b0;
    assign aw_bad = 1'b0;
`endif

    // Next-state logic for the transaction FSM and its registered outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        bresp_d  = bresp_q;
        araddr_d = araddr_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (S_AXI_ARVALID) begin
                    araddr_d = S_AXI_ARADDR;
                    cnt_d    = 4'd0;
                    if (ar_bad) begin
                        state_d = StRdResp;
                        rdata_d = 32'd0;
                        rresp_d = 2'b10;
                    end else begin
                        state_d = StRdAcc;
                    end
                end else if (aw_hs) begin
                    awaddr_d = S_AXI_AWADDR;
                    wdata_d  = S_AXI_WDATA;
                    cnt_d    = 4'd0;
                    if (aw_bad) begin
                        state_d = StWrResp;
                        bresp_d = 2'b10;
                    end else begin
                        state_d = StWrAcc;
                    end
                end
            end
            StRdAcc: begin
                if (cnt_q == LastCnt) begin
                    state_d = StRdResp;
                    rdata_d = mem_rdata;
                    rresp_d = 2'b00;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWrAcc: begin
                if (cnt_q == LastCnt) begin
                    state_d = StWrResp;
                    bresp_d = 2'b00;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRdResp: if (S_AXI_RREADY) state_d = StIdle;
            StWrResp: if (S_AXI_BREADY) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            rdata_q  <= 32'd0;
            rresp_q  <= 2'b00;
            bresp_q  <= 2'b00;
            araddr_q <= 32'd0;
            awaddr_q <= 32'd0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            bresp_q  <= bresp_d;
            araddr_q <= araddr_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign S_AXI_ARREADY = idle;
    assign S_AXI_AWREADY = aw_hs;
    assign S_AXI_WREADY  = aw_hs;
    assign S_AXI_RVALID  = (state_q == StRdResp);
    assign S_AXI_BVALID  = (state_q == StWrResp);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_BRESP   = bresp_q;
    assign mem_rd_req    = (state_q == StRdAcc);
    assign mem_wr_req    = (state_q == StWrAcc);
    assign mem_araddr    = araddr_q;
    assign mem_awaddr    = awaddr_q;
    assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_axi_mem_bridge.sv
// Self-checking bench for axi_mem_bridge: vector table plus hand-written corner sequences.
module tb_axi_mem_bridge;

    localparam int unsigned WAIT  = 3;
    localparam int          BOUND = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR;
    logic        S_AXI_AWVALID, S_AXI_WVALID, S_AXI_ARVALID, S_AXI_BREADY, S_AXI_RREADY;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    logic [31:0] mem_awaddr, mem_araddr, mem_wdata, mem_rdata;
    logic        mem_wr_req, mem_rd_req;

    axi_mem_bridge #(.WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .mem_awaddr(mem_awaddr), .mem_araddr(mem_araddr), .mem_wdata(mem_wdata),
        .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;
    } vec_t;

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out after %0d cycles at %0t", name, BOUND, $time);
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
`ifdef BRIDGE_ADDR_CHECK_EN
        return a[15:14] != 2'b00;
`else
        return a[31] & 1'b0;
`endif
    endfunction

    task automatic do_read(input logic [31:0] addr, input logic [31:0] mdata, input int delay);
        bit          bad;
        int          n;
        int          reqs;
        exp_t        e;
        logic [31:0] hold_data;
        logic [1:0]  hold_resp;
        bad    = addr_bad(addr);
        e.is_wr = 1'b0;
        e.data  = bad ? 32'd0 : mdata;
        e.resp  = bad ? 2'b10 : 2'b00;
        sb.push_back(e);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        mem_rdata     = mdata;
        S_AXI_RREADY  = (delay == 0);
        #1;
        n = 0;
        while (!S_AXI_ARREADY && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!S_AXI_ARREADY) begin
            timeout("ar_wait");
            S_AXI_ARVALID = 1'b0;
            return;
        end
        chk("awready_vs_ar", 32'(S_AXI_AWREADY), 32'd0);
        @(posedge clk);
        #1 S_AXI_ARVALID = 1'b0;
        reqs = 0;
        n    = 0;
        @(negedge clk);
        while (!S_AXI_RVALID && n < BOUND) begin
            if (mem_rd_req) begin
                if (reqs == 0) chk("mem_araddr", mem_araddr, addr);
                reqs++;
            end
            chk("arready_busy", 32'(S_AXI_ARREADY), 32'd0);
            n++;
            @(negedge clk);
        end
        if (!S_AXI_RVALID) begin
            timeout("rvalid_wait");
            return;
        end
        chk("rd_req_cycles", 32'(reqs), bad ? 32'd0 : 32'(WAIT));
        chk("rd_req_off", 32'(mem_rd_req), 32'd0);
        if (sb.size() == 0) begin
            timeout("sb_empty_rd");
        end else begin
            e = sb.pop_front();
            chk("sb_kind_rd", 32'(e.is_wr), 32'd0);
            chk("rdata", S_AXI_RDATA, e.data);
            chk("rresp", 32'(S_AXI_RRESP), 32'(e.resp));
        end
        hold_data = S_AXI_RDATA;
        hold_resp = S_AXI_RRESP;
        for (int k = 0; k < delay; k++) begin
            chk("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
            chk("rdata_hold", S_AXI_RDATA, hold_data);
            chk("rresp_hold", 32'(S_AXI_RRESP), 32'(hold_resp));
            chk("arready_hold", 32'(S_AXI_ARREADY), 32'd0);
            @(negedge clk);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge clk);
        #1 S_AXI_RREADY = 1'b0;
        @(negedge clk);
        chk("rvalid_clear", 32'(S_AXI_RVALID), 32'd0);
        chk("arready_idle", 32'(S_AXI_ARREADY), 32'd1);
        if (!bad) chk("mem_araddr_hold", mem_araddr, addr);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int delay,
                            output int waited);
        bit         bad;
        int         n;
        int         reqs;
        exp_t       e;
        logic [1:0] hold_resp;
        bad    = addr_bad(addr);
        e.is_wr = 1'b1;
        e.data  = 32'd0;
        e.resp  = bad ? 2'b10 : 2'b00;
        sb.push_back(e);
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = (delay == 0);
        #1;
        n = 0;
        while (!S_AXI_AWREADY && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (!S_AXI_AWREADY) begin
            timeout("aw_wait");
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
            return;
        end
        chk("wready_with_aw", 32'(S_AXI_WREADY), 32'd1);
        @(posedge clk);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        reqs = 0;
        n    = 0;
        @(negedge clk);
        while (!S_AXI_BVALID && n < BOUND) begin
            if (mem_wr_req) begin
                if (reqs == 0) begin
                    chk("mem_awaddr", mem_awaddr, addr);
                    chk("mem_wdata", mem_wdata, data);
                end
                reqs++;
            end
            n++;
            @(negedge clk);
        end
        if (!S_AXI_BVALID) begin
            timeout("bvalid_wait");
            return;
        end
        chk("wr_req_cycles", 32'(reqs), bad ? 32'd0 : 32'(WAIT));
        if (sb.size() == 0) begin
            timeout("sb_empty_wr");
        end else begin
            e = sb.pop_front();
            chk("sb_kind_wr", 32'(e.is_wr), 32'd1);
            chk("bresp", 32'(S_AXI_BRESP), 32'(e.resp));
        end
        hold_resp = S_AXI_BRESP;
        for (int k = 0; k < delay; k++) begin
            chk("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
            chk("bresp_hold", 32'(S_AXI_BRESP), 32'(hold_resp));
            chk("arready_whold", 32'(S_AXI_ARREADY), 32'd0);
            @(negedge clk);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge clk);
        #1 S_AXI_BREADY = 1'b0;
        @(negedge clk);
        chk("bvalid_clear", 32'(S_AXI_BVALID), 32'd0);
        if (!bad) begin
            chk("mem_awaddr_hold", mem_awaddr, addr);
            chk("mem_wdata_hold", mem_wdata, data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int bv_seen;
        vecs[0] = '{1'b0, 32'h0012_0034, 32'h00AB_CD5A, 0};
        vecs[1] = '{1'b1, 32'h0005_0010, 32'hBEEF_00C3, 0};
        vecs[2] = '{1'b0, 32'h0000_4000, 32'h1234_5678, 0};
        vecs[3] = '{1'b0, 32'h0000_1004, 32'hCAFE_F00D, 5};
        vecs[4] = '{1'b1, 32'h0000_C008, 32'h5555_AAAA, 2};
        vecs[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0};
        vecs[6] = '{1'b0, 32'hFFFF_3FFC, 32'h0000_0001, 0};

        rst           = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_WDATA   = '0;
        S_AXI_ARADDR  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_RREADY  = 1'b0;
        mem_rdata     = '0;
        repeat (2) @(negedge clk);
        chk("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        chk("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        chk("rst_rd_req", 32'(mem_rd_req), 32'd0);
        chk("rst_wr_req", 32'(mem_wr_req), 32'd0);
        chk("rst_rdata", S_AXI_RDATA, 32'd0);
        chk("rst_araddr", mem_araddr, 32'd0);
        chk("rst_arready", 32'(S_AXI_ARREADY), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].delay, waited);
            else               do_read(vecs[i].addr, vecs[i].data, vecs[i].delay);
        end

        // Simultaneous AR and AW+W: read first, write on the next idle cycle.
        S_AXI_AWADDR  = 32'h0000_0200;
        S_AXI_WDATA   = 32'h0C0F_FEE0;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        do_read(32'h0000_0100, 32'h7777_1111, 0);
        do_write(32'h0000_0200, 32'h0C0F_FEE0, 0, waited);
        chk("wr_after_rd_wait", 32'(waited), 32'd0);

        // Reset in the second write-access cycle abandons the write.
        S_AXI_AWADDR  = 32'h0000_2000;
        S_AXI_WDATA   = 32'h0BAD_0BAD;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        #1 chk("rst_seq_awready", 32'(S_AXI_AWREADY), 32'd1);
        @(posedge clk);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        @(negedge clk);
        chk("rst_seq_wr_req", 32'(mem_wr_req), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_wr_req", 32'(mem_wr_req), 32'd0);
        chk("rst_async_awaddr", mem_awaddr, 32'd0);
        chk("rst_async_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bv_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (S_AXI_BVALID || mem_wr_req) bv_seen++;
        end
        chk("rst_no_bvalid", 32'(bv_seen), 32'd0);
        S_AXI_BREADY = 1'b0;
        do_read(32'h0000_0040, 32'h2468_ACE0, 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
